// File: rtl/ad_spi_multich.sv
// Multi-channel serial-ADC front end: generates SCLK/CNVST, shifts samples in MSB-first and
// emits them tagged with their channel. Define AD_AVG_EN to average 2**AVG_LOG2 conversions per output.
module ad_spi_multich #(
    parameter int CLK_DIV  = 4,
    parameter int DATA_W   = 12,
    parameter int LATENCY  = 4,
    parameter int CONV_GAP = 31,
    parameter int N_CH     = 2,
    parameter int AVG_LOG2 = 2,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic              sdo_i,
    output logic              cnvst_o,
    output logic              sclk_o,
    output logic              cs_o,
    output logic [CH_W-1:0]   sel_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_CNT = (CONV_GAP > LATENCY) ? ((CONV_GAP > DATA_W) ? CONV_GAP : DATA_W)
                                                  : ((LATENCY > DATA_W) ? LATENCY : DATA_W);
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CONV_GAP - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, GAP, LAT, SHIFT} state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sclk_q;
    logic                cnvst_q;
    logic                valid_q;
    logic [CH_W-1:0]     sel_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-2:0]   shift_q;

    logic                riseTick;
    logic [DATA_W-1:0]   sampleWord;
    logic                emit;
    logic [DATA_W-1:0]   emitData;

    // A rise tick is the clk edge on which sclk goes 0->1; it is the only point where the ADC is sampled.
    assign riseTick   = (state_q != IDLE) && (div_q == DIV_LAST) && !sclk_q;
    assign sampleWord = {shift_q, sdo_i};

`ifdef AD_AVG_EN
    localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam logic [AVG_W-1:0] AVG_LAST = AVG_W'((1 << AVG_LOG2) - 1);

    logic [AVG_W-1:0] avgCnt_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] sum;

    assign sum      = acc_q + SUM_W'(sampleWord);
    assign emit     = (avgCnt_q == AVG_LAST);
    assign emitData = sum[SUM_W-1:AVG_LOG2];
`else
    assign emit     = 1'b1;
    assign emitData = sampleWord;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            sclk_q   <= 1'b0;
            cnvst_q  <= 1'b1;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            ch_q     <= '0;
            data_q   <= '0;
            shift_q  <= '0;
`ifdef AD_AVG_EN
            avgCnt_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (state_q == IDLE) begin
                div_q  <= '0;
                sclk_q <= 1'b0;
                if (start_i) begin
                    state_q <= GAP;
                    cnt_q   <= '0;
                    cnvst_q <= 1'b1;
                end
            end else begin
                if (div_q == DIV_LAST) begin
                    div_q  <= '0;
                    sclk_q <= ~sclk_q;
                end else begin
                    div_q <= div_q + 1'b1;
                end

                if (riseTick) begin
                    case (state_q)
                        GAP: begin
                            if (cnt_q == GAP_LAST) begin
                                cnt_q   <= '0;
                                cnvst_q <= 1'b0;
                                state_q <= (LATENCY == 0) ? SHIFT : LAT;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        LAT: begin
                            if (cnt_q == LAT_LAST) begin
                                cnt_q   <= '0;
                                state_q <= SHIFT;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        SHIFT: begin
                            shift_q <= sampleWord[DATA_W-2:0];
                            if (cnt_q == SHIFT_LAST) begin
                                cnt_q   <= '0;
                                cnvst_q <= 1'b1;
`ifdef AD_AVG_EN
                                acc_q    <= emit ? '0 : sum;
                                avgCnt_q <= emit ? '0 : avgCnt_q + 1'b1;
`endif
                                if (emit) begin
                                    data_q  <= emitData;
                                    ch_q    <= sel_q;
                                    valid_q <= 1'b1;
                                    sel_q   <= (sel_q == CH_LAST) ? '0 : sel_q + 1'b1;
                                end
                                // Stopping is only possible once a result has actually been emitted.
                                if (emit && !cont_i) begin
                                    state_q <= IDLE;
                                    sclk_q  <= 1'b0;
                                    div_q   <= '0;
                                end else begin
                                    state_q <= GAP;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign cnvst_o = cnvst_q;
    assign sclk_o  = sclk_q;
    assign cs_o    = 1'b0;
    assign sel_o   = sel_q;
    assign data_o  = data_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);

endmodule
